// File: rtl/mist1032isa_uart_pkg.sv
// Shared types and constants for the MIST1032ISA UART transmit path.
// Optional even parity is selected with MIST1032ISA_UART_TX_PARITY_EN.
package mist1032isa_uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_OVERSAMPLE = 4;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'h0,
    TX_START  = 3'h1,
    TX_DATA   = 3'h2,
    TX_PARITY = 3'h3,
    TX_STOP   = 3'h4
  } tx_state_t;

  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mist1032isa_uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; fullness is judged on the pre-edge count,
// so a push against a full FIFO is dropped even when a pop happens on that edge.
module mist1032isa_uart_tx_fifo
  import mist1032isa_uart_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                   b_bd_clock,
  input  logic                   inRESET,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] pop_data,
  output logic                   full,
  output logic                   empty,
  output logic                   overrun
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2+1)'(DEPTH);

  logic [UART_DATA_W-1:0]     mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       push_ok;
  logic                       pop_ok;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge b_bd_clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly FIFO_DEPTH_LOG2 wide, so they wrap modulo DEPTH.
  always_ff @(posedge b_bd_clock or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mist1032isa_uart_tx_serializer.sv
// UART transmit serializer: FIFO-fed LSB-first 8N1/8N2 frames, each bit held
// SAMPLES_PER_BIT ticks. Define MIST1032ISA_UART_TX_PARITY_EN for an even parity bit.
module mist1032isa_uart_tx_serializer
  import mist1032isa_uart_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = UART_OVERSAMPLE,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                   b_bd_clock,
  input  logic                   inRESET,
  input  logic                   iTX_VALID,
  input  logic [UART_DATA_W-1:0] iTX_DATA,
  output logic                   oTX_FULL,
  output logic                   oTX_EMPTY,
  output logic                   oTX_BUSY,
  output logic                   oTX_OVERRUN,
  output logic                   oUART_TXD,
  output tx_state_t              dbg_state
);

  localparam int TICK_W = $clog2(2*SAMPLES_PER_BIT);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(SAMPLES_PER_BIT-1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_BITS*SAMPLES_PER_BIT-1);

  tx_state_t              state;
  logic [TICK_W-1:0]      tick;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shift;
  logic                   txd;
  logic                   fifo_pop;
  logic [UART_DATA_W-1:0] fifo_data;
  logic                   fifo_empty;
  logic                   bit_last;
`ifdef MIST1032ISA_UART_TX_PARITY_EN
  logic                   parity_bit;
`endif

  mist1032isa_uart_tx_fifo #(
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .b_bd_clock(b_bd_clock),
    .inRESET   (inRESET),
    .push      (iTX_VALID),
    .push_data (iTX_DATA),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (oTX_FULL),
    .empty     (fifo_empty),
    .overrun   (oTX_OVERRUN)
  );

  // The final stop tick doubles as the next frame's load point, so frames abut.
  assign bit_last = (tick == BIT_LAST);
  assign fifo_pop = !fifo_empty &&
                    ((state == TX_IDLE) || ((state == TX_STOP) && (tick == STOP_LAST)));

  always_ff @(posedge b_bd_clock or negedge inRESET) begin
    if (!inRESET) begin
      state   <= TX_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      txd     <= 1'b1;
`ifdef MIST1032ISA_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (fifo_pop) begin
            shift <= fifo_data;
            tick  <= '0;
            state <= TX_START;
            txd   <= 1'b0;
`ifdef MIST1032ISA_UART_TX_PARITY_EN
            parity_bit <= even_parity(fifo_data);
`endif
          end
        end
        TX_START: begin
          if (bit_last) begin
            state   <= TX_DATA;
            tick    <= '0;
            bit_cnt <= '0;
            txd     <= shift[0];
          end else begin
            tick <= tick + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_last) begin
            tick <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef MIST1032ISA_UART_TX_PARITY_EN
              state <= TX_PARITY;
              txd   <= parity_bit;
`else
              state <= TX_STOP;
              txd   <= 1'b1;
`endif
            end else begin
              shift   <= shift >> 1;
              txd     <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
`ifdef MIST1032ISA_UART_TX_PARITY_EN
        TX_PARITY: begin
          if (bit_last) begin
            state <= TX_STOP;
            tick  <= '0;
            txd   <= 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (tick == STOP_LAST) begin
            tick <= '0;
            if (fifo_pop) begin
              shift <= fifo_data;
              state <= TX_START;
              txd   <= 1'b0;
`ifdef MIST1032ISA_UART_TX_PARITY_EN
              parity_bit <= even_parity(fifo_data);
`endif
            end else begin
              state <= TX_IDLE;
              txd   <= 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: begin
          state <= TX_IDLE;
          tick  <= '0;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  assign oUART_TXD = txd;
  assign oTX_EMPTY = fifo_empty;
  assign oTX_BUSY  = (state != TX_IDLE);
  assign dbg_state = state;

endmodule
